// File: rtl/aes_inv_cipher_ctrl_if.sv
// Bus and datapath handshake bundle for the AES-128 inverse cipher controller.
// Pure wiring: no storage, no added latency.
// Backpressure comes from the datapath finish strobes and hreadyout back to the bus.
interface aes_inv_cipher_ctrl_if #(
  parameter int RND_W = 4
);
  // AHB-slave-side request qualifiers
  logic             hsel;
  logic             addr_match;
  logic             m_write;
  logic             m_read;
  logic             data_ready;
  logic             invalid;
  // Datapath completion strobes
  logic             keyexp_finished;
  logic             isrows_finished;
  logic             isbytes_finished;
  logic             around_finished;
  logic             imcol_finished;
  // Bus responses
  logic             hreadyout;
  logic             hresp_error;
  // Datapath controls
  logic             readk_enable;
  logic             read_enable;
  logic             write_enable;
  logic             keyexp_enable;
  logic             key_wr_en;
  logic [RND_W-1:0] key_addr;
  logic             isrows_enable;
  logic             isbytes_enable;
  logic             around_enable;
  logic             imcol_enable;
  logic             busy;
  logic [RND_W-1:0] roundnum;

  // Controller view: it is the slave on the bus and drives the datapath.
  modport slave (
    input  hsel, addr_match, m_write, m_read, data_ready, invalid,
    input  keyexp_finished, isrows_finished, isbytes_finished,
    input  around_finished, imcol_finished,
    output hreadyout, hresp_error, readk_enable, read_enable, write_enable,
    output keyexp_enable, key_wr_en, key_addr, isrows_enable, isbytes_enable,
    output around_enable, imcol_enable, busy, roundnum
  );

  // Environment view: bus interface plus datapath units.
  modport master (
    output hsel, addr_match, m_write, m_read, data_ready, invalid,
    output keyexp_finished, isrows_finished, isbytes_finished,
    output around_finished, imcol_finished,
    input  hreadyout, hresp_error, readk_enable, read_enable, write_enable,
    input  keyexp_enable, key_wr_en, key_addr, isrows_enable, isbytes_enable,
    input  around_enable, imcol_enable, busy, roundnum
  );
endinterface

// File: rtl/aes_inv_cipher_ctrl.sv
// AES-128 decryption sequencer: key load + round-key pre-expansion, then inverse rounds.
// Outputs registered from next state (valid the cycle the state is entered); hreadyout is combinational.
// Each datapath enable holds until its finish strobe; bus requests are ignored while busy.
module aes_inv_cipher_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int RND_W      = 4
) (
  input logic                clk,
  input logic                n_rst,
  aes_inv_cipher_ctrl_if.slave bus
);

  typedef enum logic [4:0] {
    IDLEK, RADDRK, ERRK, WAITK, READK, KWR, KEXP,
    IDLE, RADDR, ERR, WAIT, READD, ARK, IMCOL, ISROWS, ISBYTES, DONE, SEND
  } state_t;

  localparam logic [RND_W-1:0] LAST = RND_W'(NUM_ROUNDS);

  state_t           state_q, state_d;
  logic [RND_W-1:0] key_addr_q, key_addr_d;
  logic [RND_W-1:0] round_q, round_d;

  logic readk_q, readk_d, read_q, read_d, write_q, write_d;
  logic keyexp_q, keyexp_d, key_wr_q, key_wr_d;
  logic isrows_q, isrows_d, isbytes_q, isbytes_d;
  logic around_q, around_d, imcol_q, imcol_d;
  logic herr_q, herr_d, busy_q, busy_d;

  // Next-state and counter updates
  always_comb begin
    state_d    = state_q;
    key_addr_d = key_addr_q;
    round_d    = round_q;
    case (state_q)
      IDLEK:   if (bus.hsel) state_d = RADDRK;
      RADDRK: begin
        if (bus.invalid)                       state_d = ERRK;
        else if (bus.addr_match && bus.m_write) state_d = WAITK;
      end
      ERRK:    if (bus.hsel) state_d = RADDRK;
      WAITK:   if (bus.data_ready) state_d = READK;
      READK: begin
        key_addr_d = '0;
        state_d    = KWR;
      end
      // Round key at key_addr is stored; after the last one the key phase ends.
      KWR:     state_d = (key_addr_q == LAST) ? IDLE : KEXP;
      KEXP: begin
        if (bus.keyexp_finished) begin
          key_addr_d = key_addr_q + 1'b1;
          state_d    = KWR;
        end
      end
      IDLE:    if (bus.hsel) state_d = RADDR;
      RADDR: begin
        if (bus.invalid)          state_d = ERR;
        else if (!bus.addr_match) state_d = IDLE;
        else if (bus.m_read)      state_d = SEND;
        else if (bus.m_write)     state_d = WAIT;
      end
      ERR:     if (bus.hsel) state_d = RADDR;
      WAIT:    if (bus.data_ready) state_d = READD;
      READD: begin
        round_d    = LAST;
        key_addr_d = LAST;
        state_d    = ARK;
      end
      // Round 0's AddRoundKey finishes the block; the first inverse round skips InvMixColumns.
      ARK: begin
        if (bus.around_finished) begin
          if (round_q == '0) begin
            state_d = DONE;
          end else begin
            round_d    = round_q - 1'b1;
            key_addr_d = key_addr_q - 1'b1;
            state_d    = (round_q == LAST) ? ISROWS : IMCOL;
          end
        end
      end
      IMCOL:   if (bus.imcol_finished)   state_d = ISROWS;
      ISROWS:  if (bus.isrows_finished)  state_d = ISBYTES;
      ISBYTES: if (bus.isbytes_finished) state_d = ARK;
      DONE: begin
        round_d = '0;
        state_d = IDLE;
      end
      SEND:    state_d = IDLE;
      default: state_d = IDLEK;
    endcase
  end

  // Output decode from the next state so registered outputs track the state exactly
  always_comb begin
    readk_d   = (state_d == READK);
    read_d    = (state_d == READD);
    write_d   = (state_d == SEND);
    keyexp_d  = (state_d == KEXP);
    key_wr_d  = (state_d == KWR);
    isrows_d  = (state_d == ISROWS);
    isbytes_d = (state_d == ISBYTES);
    around_d  = (state_d == ARK);
    imcol_d   = (state_d == IMCOL);
    herr_d    = (state_d == ERRK) || (state_d == ERR);
    busy_d    = (state_d == KWR)    || (state_d == KEXP)    || (state_d == ARK) ||
                (state_d == ISROWS) || (state_d == ISBYTES) || (state_d == IMCOL);
  end

  // State, counters and registered outputs; reset aborts any operation
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLEK;
      key_addr_q <= '0;
      round_q    <= '0;
      readk_q    <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      keyexp_q   <= 1'b0;
      key_wr_q   <= 1'b0;
      isrows_q   <= 1'b0;
      isbytes_q  <= 1'b0;
      around_q   <= 1'b0;
      imcol_q    <= 1'b0;
      herr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_addr_q <= key_addr_d;
      round_q    <= round_d;
      readk_q    <= readk_d;
      read_q     <= read_d;
      write_q    <= write_d;
      keyexp_q   <= keyexp_d;
      key_wr_q   <= key_wr_d;
      isrows_q   <= isrows_d;
      isbytes_q  <= isbytes_d;
      around_q   <= around_d;
      imcol_q    <= imcol_d;
      herr_q     <= herr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.hreadyout      = (state_q == DONE) || (state_q == SEND);
  assign bus.hresp_error    = herr_q;
  assign bus.readk_enable   = readk_q;
  assign bus.read_enable    = read_q;
  assign bus.write_enable   = write_q;
  assign bus.keyexp_enable  = keyexp_q;
  assign bus.key_wr_en      = key_wr_q;
  assign bus.key_addr       = key_addr_q;
  assign bus.isrows_enable  = isrows_q;
  assign bus.isbytes_enable = isbytes_q;
  assign bus.around_enable  = around_q;
  assign bus.imcol_enable   = imcol_q;
  assign bus.busy           = busy_q;
  assign bus.roundnum       = round_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for the AES-128 inverse cipher controller.
module tb_aes_inv_cipher_ctrl;

  localparam int RND_W = 4;

  // ctl bit positions; bits 0..4 also index the finish strobes
  localparam int IMC = 0;
  localparam int ARKB = 1;
  localparam int ISB = 2;
  localparam int ISR = 3;
  localparam int KEX = 4;
  localparam int KWRB = 5;

  logic       clk;
  logic       n_rst;
  logic [4:0] fin;
  int         n_assert;
  int         n_fail;

  aes_inv_cipher_ctrl_if #(.RND_W(RND_W)) bus ();

  aes_inv_cipher_ctrl #(.NUM_ROUNDS(10), .RND_W(RND_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  assign bus.imcol_finished   = fin[IMC];
  assign bus.around_finished  = fin[ARKB];
  assign bus.isbytes_finished = fin[ISB];
  assign bus.isrows_finished  = fin[ISR];
  assign bus.keyexp_finished  = fin[KEX];

  wire [5:0] ctl = {bus.key_wr_en, bus.keyexp_enable, bus.isrows_enable,
                    bus.isbytes_enable, bus.around_enable, bus.imcol_enable};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Wait (bounded) for control bit idx, then require it to be the only control active
  task automatic wait_ctl(input int idx, input string tag);
    logic [5:0] e;
    e = '0;
    e[idx] = 1'b1;
    for (int i = 0; i < 30 && !ctl[idx]; i++) tick();
    chk(tag, 32'(ctl), 32'(e));
  endtask

  // Pulse the finish strobe dly cycles later; the enable must drop on that edge
  task automatic finish(input int idx, input int dly, input string tag);
    repeat (dly) tick();
    fin[idx] = 1'b1;
    tick();
    fin[idx] = 1'b0;
    chk(tag, 32'(ctl[idx]), 32'd0);
  endtask

  // Key load from IDLEK or RADDRK; returns early while in KEXP at key_addr == abort_at
  task automatic do_key_load(input int abort_at);
    bus.hsel = 1'b1;
    tick();
    bus.hsel       = 1'b0;
    bus.addr_match = 1'b1;
    bus.m_write    = 1'b1;
    tick();
    bus.addr_match = 1'b0;
    bus.m_write    = 1'b0;
    bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    chk("readk_enable", 32'(bus.readk_enable), 32'd1);
    chk("readk_not_busy", 32'(bus.busy), 32'd0);
    tick();
    for (int k = 0; k <= 10; k++) begin
      wait_ctl(KWRB, "kwr_only");
      chk("kwr_addr", 32'(bus.key_addr), 32'(k));
      chk("kwr_busy", 32'(bus.busy), 32'd1);
      if (k == 10) break;
      tick();
      wait_ctl(KEX, "kexp_only");
      chk("kexp_addr", 32'(bus.key_addr), 32'(k));
      if (k == abort_at) return;
      finish(KEX, 3, "kexp_drop");
    end
    tick();
    chk("keyload_end_busy", 32'(bus.busy), 32'd0);
    chk("keyload_end_ctl", 32'(ctl), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    n_rst    = 1'b0;
    fin      = '0;
    bus.hsel = 1'b0;
    bus.addr_match = 1'b0;
    bus.m_write    = 1'b0;
    bus.m_read     = 1'b0;
    bus.data_ready = 1'b0;
    bus.invalid    = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_ctl", 32'(ctl), 32'd0);
    chk("rst_key_addr", 32'(bus.key_addr), 32'd0);
    chk("rst_roundnum", 32'(bus.roundnum), 32'd0);
    chk("rst_hreadyout", 32'(bus.hreadyout), 32'd0);
    chk("rst_hresp", 32'(bus.hresp_error), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rw", 32'({bus.readk_enable, bus.read_enable, bus.write_enable}), 32'd0);
    n_rst = 1'b1;
    tick();

    // Illegal transfer in RADDRK: error held until hsel
    bus.hsel = 1'b1;
    tick();
    bus.hsel    = 1'b0;
    bus.invalid = 1'b1;
    tick();
    bus.invalid = 1'b0;
    chk("errk_hresp", 32'(bus.hresp_error), 32'd1);
    repeat (2) tick();
    chk("errk_hresp_hold", 32'(bus.hresp_error), 32'd1);
    bus.hsel = 1'b1;
    tick();
    bus.hsel = 1'b0;
    chk("errk_exit_hresp", 32'(bus.hresp_error), 32'd0);

    // Partial key load aborted by reset in KEXP at key_addr 4
    do_key_load(4);
    n_rst = 1'b0;
    #1;
    chk("midrst_ctl", 32'(ctl), 32'd0);
    chk("midrst_key_addr", 32'(bus.key_addr), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    tick();
    n_rst = 1'b1;
    tick();

    // Full key load from IDLEK
    do_key_load(-1);

    // Illegal transfer in RADDR: ERR, key store untouched, back to RADDR on hsel
    bus.hsel = 1'b1;
    tick();
    bus.hsel    = 1'b0;
    bus.invalid = 1'b1;
    tick();
    bus.invalid = 1'b0;
    chk("err_hresp", 32'(bus.hresp_error), 32'd1);
    chk("err_no_keywr", 32'(bus.key_wr_en), 32'd0);
    tick();
    chk("err_hresp_hold", 32'(bus.hresp_error), 32'd1);
    bus.hsel = 1'b1;
    tick();
    bus.hsel = 1'b0;
    chk("err_exit_hresp", 32'(bus.hresp_error), 32'd0);

    // Read request from RADDR: one-cycle SEND, no datapath enables
    bus.addr_match = 1'b1;
    bus.m_read     = 1'b1;
    tick();
    bus.addr_match = 1'b0;
    bus.m_read     = 1'b0;
    chk("send_write_enable", 32'(bus.write_enable), 32'd1);
    chk("send_hreadyout", 32'(bus.hreadyout), 32'd1);
    chk("send_ctl", 32'(ctl), 32'd0);
    tick();
    chk("send_exit", 32'({bus.write_enable, bus.hreadyout}), 32'd0);

    // One ciphertext block
    bus.hsel = 1'b1;
    tick();
    bus.hsel       = 1'b0;
    bus.addr_match = 1'b1;
    bus.m_write    = 1'b1;
    tick();
    bus.addr_match = 1'b0;
    bus.m_write    = 1'b0;
    bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    chk("readd_read_enable", 32'(bus.read_enable), 32'd1);
    chk("readd_readk", 32'(bus.readk_enable), 32'd0);
    tick();
    for (int r = 10; r >= 0; r--) begin
      wait_ctl(ARKB, "ark_only");
      chk("ark_key_addr", 32'(bus.key_addr), 32'(r));
      chk("ark_roundnum", 32'(bus.roundnum), 32'(r));
      chk("ark_busy", 32'(bus.busy), 32'd1);
      finish(ARKB, 2, "ark_drop");
      if (r == 0) break;
      if (r != 10) begin
        wait_ctl(IMC, "imcol_only");
        chk("imcol_key_addr", 32'(bus.key_addr), 32'(r - 1));
        finish(IMC, 2, "imcol_drop");
      end
      wait_ctl(ISR, "isrows_only");
      finish(ISR, 2, "isrows_drop");
      wait_ctl(ISB, "isbytes_only");
      if (r == 5) begin
        fin[IMC] = 1'b1;
        repeat (2) tick();
        fin[IMC] = 1'b0;
        chk("spurious_imcol_ignored", 32'(ctl), 32'(6'b000100));
      end
      finish(ISB, 2, "isbytes_drop");
    end
    chk("done_hreadyout", 32'(bus.hreadyout), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_roundnum", 32'(bus.roundnum), 32'd0);
    tick();
    chk("idle_hreadyout", 32'(bus.hreadyout), 32'd0);
    chk("idle_ctl", 32'(ctl), 32'd0);

    // Back in IDLE: a read request is accepted directly
    bus.hsel = 1'b1;
    tick();
    bus.hsel       = 1'b0;
    bus.addr_match = 1'b1;
    bus.m_read     = 1'b1;
    tick();
    bus.addr_match = 1'b0;
    bus.m_read     = 1'b0;
    chk("post_send_write_enable", 32'(bus.write_enable), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
